// File: rtl/ifu_seq.sv
// Instruction fetch unit for the SCPU core: owns the PC, fetches one word per
// instruction over a req/rvalid handshake and computes the next PC on retire.
module ifu_seq #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             inst_done,
  input  logic [1:0]       NPCOp,
  input  logic [31:0]      RD1,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] npc;
  logic [31:0] br_off;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= BOOT;
    else       state <= state_nxt;
  end

  // Handshake outputs come only from the state register, never from inputs.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) state_nxt = EXEC;
      end
      EXEC: begin
        inst_valid = 1'b1;
        if (inst_done) state_nxt = FETCH;
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign br_off    = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (NPCOp)
      2'b00: npc = pc_plus4;
      2'b01: npc = pc_plus4 + br_off;
      2'b10: npc = {pc_plus4[31:28], inst[25:0], 2'b00};
      2'b11: npc = RD1 & 32'hFFFF_FFFC;
      default: npc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc     <= PC_RESET;
      inst   <= 32'h0;
      icount <= '0;
    end else begin
      if (state == FETCH && imem_rvalid) inst <= imem_rdata;
      if (state == EXEC && inst_done) begin
        pc     <= npc;
        icount <= icount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifu_seq.sv
// Self-checking bench for ifu_seq: directed vector table, hand-written corner
// sequences and randomized instructions checked against a next-PC model.
module tb_ifu_seq;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rstn;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             inst_valid;
  logic [31:0]      inst;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             inst_done;
  logic [1:0]       NPCOp;
  logic [31:0]      RD1;
  logic [CNT_W-1:0] icount;

  int tests_run;
  int tests_failed;

  logic [31:0] model_pc;
  int          model_icount;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  op;
    logic [31:0] rd1;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  ifu_seq #(.PC_RESET(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .pc_plus4(pc_plus4),
    .inst_done(inst_done), .NPCOp(NPCOp), .RD1(RD1), .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC computed from the architectural rules with plain arithmetic.
  function automatic logic [31:0] ref_npc(input logic [31:0] cur_pc, input logic [31:0] word,
                                          input logic [1:0] op, input logic [31:0] rd1);
    logic [31:0] seq;
    int          off;
    seq = cur_pc + 32'd4;
    case (op)
      2'd0: return seq;
      2'd1: begin
        off = int'($signed(word[15:0])) * 4;
        return seq + 32'(off);
      end
      2'd2: return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
      default: return (rd1 >> 2) << 2;
    endcase
  endfunction

  task automatic checkCount(input string name);
    checkOutput(name, 32'(icount), 32'(model_icount % (1 << CNT_W)));
  endtask

  // One full fetch/execute round, called on a falling edge with the DUT in FETCH.
  task automatic applyStimulus(input logic [31:0] word, input int rv_delay,
                               input logic [1:0] op, input logic [31:0] rd1,
                               input int done_delay);
    int n;
    int cyc;
    n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fetch_req", 32'(imem_req), 32'd1);
    checkOutput("fetch_addr", imem_addr, model_pc);
    cyc = 0;
    for (int i = 0; i < rv_delay; i++) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      inst_done   = (i == 0);
      NPCOp       = 2'($urandom);
      RD1         = $urandom;
      @(negedge clk);
      cyc++;
      checkOutput("wait_addr_stable", imem_addr, model_pc);
      checkOutput("wait_req_held", 32'(imem_req), 32'd1);
      checkOutput("wait_no_valid", 32'(inst_valid), 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    inst_done   = 1'b0;
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    checkOutput("exec_valid", 32'(inst_valid), 32'd1);
    checkOutput("exec_req_low", 32'(imem_req), 32'd0);
    checkOutput("exec_inst", inst, word);
    checkOutput("exec_pc", pc, model_pc);
    checkOutput("exec_pc_plus4", pc_plus4, model_pc + 32'd4);
    for (int i = 0; i < done_delay; i++) begin
      imem_rvalid = (i == 0);
      imem_rdata  = $urandom;
      NPCOp       = 2'($urandom);
      RD1         = $urandom;
      @(negedge clk);
      cyc++;
      checkOutput("exec_inst_stable", inst, word);
      checkOutput("exec_pc_stable", pc, model_pc);
      checkOutput("exec_still_valid", 32'(inst_valid), 32'd1);
    end
    imem_rvalid = 1'b0;
    inst_done   = 1'b1;
    NPCOp       = op;
    RD1         = rd1;
    @(negedge clk);
    cyc++;
    inst_done = 1'b0;
    NPCOp     = 2'($urandom);
    RD1       = $urandom;
    model_pc  = ref_npc(model_pc, word, op, rd1);
    model_icount++;
    checkOutput("retire_pc", pc, model_pc);
    checkOutput("retire_next_addr", imem_addr, model_pc);
    checkOutput("retire_req", 32'(imem_req), 32'd1);
    checkOutput("retire_valid_low", 32'(inst_valid), 32'd0);
    checkCount("retire_icount");
    checkOutput("period_cycles", 32'(cyc), 32'(rv_delay + done_delay + 2));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    vecs[0]  = '{32'h2000_0002, 2'd0, 32'h0,         32'h0000_0008};
    vecs[1]  = '{32'h2000_0003, 2'd0, 32'h0,         32'h0000_000C};
    vecs[2]  = '{32'h0000_0008, 2'd3, 32'h0000_0010, 32'h0000_0010};
    vecs[3]  = '{32'h1000_FFFE, 2'd1, 32'h0,         32'h0000_000C};
    vecs[4]  = '{32'h0000_0008, 2'd3, 32'h7FFF_FFFC, 32'h7FFF_FFFC};
    vecs[5]  = '{32'h1000_0000, 2'd1, 32'h0,         32'h8000_0000};
    vecs[6]  = '{32'h0000_0008, 2'd3, 32'h3000_0000, 32'h3000_0000};
    vecs[7]  = '{32'h0800_0010, 2'd2, 32'h0,         32'h3000_0040};
    vecs[8]  = '{32'h0000_0008, 2'd3, 32'h0000_1237, 32'h0000_1234};
    vecs[9]  = '{32'h0BFF_FFFF, 2'd2, 32'h0,         32'h0FFF_FFFC};
    vecs[10] = '{32'h2000_0004, 2'd0, 32'h0,         32'h1000_0000};
    vecs[11] = '{32'h0000_0008, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[12] = '{32'h2000_0005, 2'd0, 32'h0,         32'h0000_0000};
    vecs[13] = '{32'h1000_7FFF, 2'd1, 32'h0,         32'h0002_0000};

    rstn        = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2000_0001;
    inst_done   = 1'b0;
    NPCOp       = 2'd0;
    RD1         = 32'h0;
    model_pc    = 32'h0;
    model_icount = 0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_req", 32'(imem_req), 32'd0);
    checkOutput("reset_valid", 32'(inst_valid), 32'd0);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_inst", inst, 32'h0);
    checkCount("reset_icount");

    // Boot with memory that always answers immediately.
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("boot_req_rise", 32'(imem_req), 32'd1);
    checkOutput("boot_addr", imem_addr, 32'h0);
    checkOutput("boot_no_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkOutput("boot_valid_rise", 32'(inst_valid), 32'd1);
    checkOutput("boot_pc", pc, 32'h0);
    checkOutput("boot_inst", inst, 32'h2000_0001);
    inst_done = 1'b1;
    @(negedge clk);
    inst_done    = 1'b0;
    model_pc     = 32'h4;
    model_icount = 1;
    checkOutput("boot_retire_pc", pc, 32'h4);

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].word, 0, vecs[v].op, vecs[v].rd1, 0);
      checkOutput($sformatf("vec%0d_pc", v), pc, vecs[v].exp_pc);
      if (v == 1) checkOutput("seq_icount_3", 32'(icount), 32'd3);
    end

    // Sixteenth retire wraps the narrow counter back to zero.
    applyStimulus(32'h2000_0006, 3, 2'd0, 32'h0, 2);
    checkOutput("icount_wrap", 32'(icount), 32'd0);
    applyStimulus(32'h1000_0003, 1, 2'd1, 32'h0, 3);

    for (int r = 0; r < 40; r++) begin
      applyStimulus($urandom, int'($urandom_range(0, 3)), 2'($urandom), $urandom,
                    int'($urandom_range(0, 3)));
    end

    // Asynchronous reset while a fetch is outstanding at pc 0x20.
    applyStimulus(32'h0000_0008, 0, 2'd3, 32'h0000_0020, 0);
    checkOutput("pre_reset_pc", pc, 32'h20);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_req", 32'(imem_req), 32'd0);
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_icount", 32'(icount), 32'd0);
    checkOutput("async_inst", inst, 32'h0);
    model_pc     = 32'h0;
    model_icount = 0;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'hBAD0_BAD0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_req", 32'(imem_req), 32'd1);
    checkOutput("post_reset_ignore_rvalid", inst, 32'h0);
    checkOutput("post_reset_no_valid", 32'(inst_valid), 32'd0);
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkOutput("post_reset_inst", inst, 32'h1234_5678);
    checkOutput("post_reset_valid", 32'(inst_valid), 32'd1);
    inst_done = 1'b1;
    NPCOp     = 2'd0;
    @(negedge clk);
    inst_done = 1'b0;
    checkOutput("post_reset_retire_pc", pc, 32'h4);
    checkOutput("post_reset_icount", 32'(icount), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ifu_seq.md
Name: ifu_seq

Overview:
- Instruction fetch unit for the SCPU core. Sits directly upstream of the control decoder.
- Holds the PC and fetches one instruction from instruction memory over a req/rvalid handshake.
- Presents the instruction (Op/Funct/rs/rt/imm fields) to decode and the datapath.
- Computes the next PC from the decoder's NPCOp when the datapath retires the instruction.
- One instruction in flight; a minimum of 2 cycles per instruction.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch byte address, word aligned
- imem_rvalid  input  1  instruction memory data valid
- imem_rdata  input  32  instruction word
- inst_valid  output  1  inst/pc outputs hold a valid instruction awaiting execution
- inst  output  32  instruction register, to the decoder and datapath
- pc  output  32  address of inst
- pc_plus4  output  32  pc+4, used as the jal/jalr link value
- inst_done  input  1  datapath retires inst this cycle; NPCOp/RD1 valid
- NPCOp  input  2  00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR
- RD1  input  32  rs register value, the JR/JALR target
- icount  output  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values:
  - State = BOOT.
  - pc = PC_RESET; inst = 32'h0; icount = 0.
  - inst_valid = 0; imem_req = 0.
- Reset asserted mid-operation:
  - All outputs take reset values immediately, without waiting for a clock edge.
  - An outstanding fetch is abandoned.
  - An imem_rvalid arriving after reset releases is ignored until the FSM is in FETCH.
- State machine (3 states):
  - BOOT: imem_req=0. Goes to FETCH on the first clock after rstn deasserts.
  - FETCH:
    - imem_req=1 and imem_addr=pc, held stable until imem_rvalid.
    - On a clock with imem_rvalid=1: inst <= imem_rdata, then go to EXEC.
    - imem_rvalid may be high in the same cycle req rises (zero-wait memory); the instruction is accepted that cycle.
  - EXEC:
    - imem_req=0, inst_valid=1.
    - inst and pc are held stable until inst_done.
    - On a clock with inst_done=1: pc <= npc, icount <= icount+1, then go to FETCH.
- Outputs derived from state: inst_valid=1 only in EXEC. imem_req=1 only in FETCH. Both are decoded from the state register, with no combinational path from the inputs.
- Ignored inputs:
  - imem_rvalid is ignored outside FETCH.
  - inst_done is ignored outside EXEC.
  - NPCOp and RD1 are sampled only on the inst_done cycle.
- pc_plus4 = pc + 32'd4, combinational, wraps modulo 2^32.
- Next-PC computation (npc):
  - PLUS4: pc_plus4.
  - BRANCH: pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}, 32-bit wrap.
  - JUMP: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - JR: {RD1[31:2], 2'b00}. Low two bits are forced to zero; no exception is raised.
- Branch condition: BRANCH is applied unconditionally. The decoder has already folded Zero into NPCOp.
- icount: increments once per retired instruction and wraps from all-ones to 0.

Test Plan:
- Reset/boot:
  - Stimulus: rstn low, then high; imem_rvalid tied to 1.
  - Required response: imem_req rises the cycle after release with imem_addr=0. inst_valid rises one cycle later with pc=0.
- Sequential flow:
  - Stimulus: zero-wait memory; inst_done pulsed every EXEC cycle with NPCOp=00.
  - Required response: pc steps 0, 4, 8, 12. icount=3 after three retires. Period is 2 cycles per instruction.
- Branch:
  - Stimulus: pc=0x10, inst=0x1000FFFE (beq, offset -2), NPCOp=01.
  - Required response: next imem_addr=0x0C.
  - Stimulus: pc=0x7FFFFFFC with offset 0.
  - Required response: next imem_addr=0x80000000.
- Jump/JR:
  - Stimulus: pc=0x30000000, inst=0x08000010, NPCOp=10.
  - Required response: next pc=0x30000040.
  - Stimulus: NPCOp=11, RD1=0x00001237.
  - Required response: next pc=0x00001234.
- Wait states:
  - Stimulus: imem_rvalid delayed 3 cycles; inst_done delayed 2 cycles.
  - Required response: imem_addr stable while waiting. inst and pc stable during EXEC. Spurious inst_done during FETCH and spurious rvalid during EXEC cause no change.
- Async reset mid-fetch:
  - Stimulus: rstn dropped while imem_req=1 and pc=0x20.
  - Required response: imem_req=0, pc=PC_RESET and icount=0 before the next clock edge.
